// File: rtl/rr_mux_sequencer.sv
// rr_mux_sequencer: round-robin arbiter that steers a shared 32:1 select mux
// and captures the selected word into a one-entry valid/ready output register.
module rr_mux_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  req,
    output logic [31:0]  gnt,
    output logic [4:0]   sel,
    input  logic [N-1:0] mux_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [4:0]   out_src
);

    logic [4:0]  ptr;
    logic [63:0] req_dbl;
    logic [31:0] req_rot;
    logic [4:0]  off;
    logic [4:0]  winner;
    logic        any;
    logic        load;

    // Output slot is free, or is being drained on this same edge.
    assign load = rst_n & (~out_valid | out_ready);

    // Rotate requests so bit 0 is the pointer position, then take the lowest
    // set bit; adding the offset back to ptr wraps naturally in 5 bits.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[31:0];
        off     = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (req_rot[i]) off = 5'(i);
        end
        any    = |req;
        winner = ptr + off;
        sel    = any ? winner : 5'd0;
        gnt    = (load && any) ? (32'd1 << winner) : 32'd0;
    end

    // Capture the granted word and advance the pointer past the winner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 5'd0;
            ptr       <= 5'd0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_src   <= winner;
                ptr       <= winner + 5'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_mux_sequencer.md
Name: rr_mux_sequencer

Overview:
- Round-robin scheduler that shares the 32:1 N-bit select mux among 32 requesters.
- Each cycle it picks one requesting source and drives the mux select with that source's index.
- It captures the mux output into a one-entry output register and presents it downstream with a valid/ready handshake.
- It sits between the 32 source ports (feeding mux inputs i0..i31) and a single downstream consumer.

Parameters:
- N, 8, data width of each mux input and of out_data.

Ports:
- clk  input  1  rising-edge clock; sole clock of the block.
- rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
- req  input  32  req[k]=1: source k has a word on mux input ik.
- gnt  output  32  one-hot combinational grant; req[k]&gnt[k] at a clock edge = word from source k transferred.
- sel  output  5  mux select, combinational; index of current winner.
- mux_data  input  N  mux output, returned from the mux.
- out_valid  output  1  out_data/out_src hold a valid word.
- out_ready  input  1  downstream accepts the word when out_valid&out_ready at a clock edge.
- out_data  output  N  registered captured word.
- out_src  output  5  registered index of the source that supplied out_data.

Behaviour:
- Reset (rst_n=0 at an edge) forces these values:
  - out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=0.
  - Reset mid-transfer discards the held word; no gnt is issued in a reset cycle.
- Load condition: load = rst_n & (~out_valid | out_ready). The output register is empty or is being drained this cycle.
- Arbitration is combinational, every cycle:
  - winner = first k with req[k]=1, scanning ptr, ptr+1, ..., 31, 0, ..., ptr-1 (mod 32).
  - any = |req.
- sel = winner if any, else 5'd0. sel does not depend on load, so the mux path settles before the edge.
- gnt = one-hot(winner) when load & any, else 32'b0. gnt is never multi-hot.
- On a clock edge with load & any:
  - out_data <= mux_data, out_src <= winner, out_valid <= 1.
  - ptr <= winner+1 mod 32 (31 wraps to 0).
- On a clock edge with load & ~any:
  - out_valid <= 0.
  - out_data, out_src and ptr hold.
- On a clock edge with ~load (out_valid=1, out_ready=0, backpressure):
  - out_data, out_src, out_valid and ptr hold.
  - gnt=0 and requests stay pending.
- Latency: a request granted at edge t appears with out_valid=1 after edge t (1 cycle).
- Throughput: one word per cycle while out_ready=1 and any=1. Simultaneous drain and load in the same cycle is legal and produces no bubble.
- Fairness:
  - A requester holding req high waits at most 31 grants to other sources.
  - A single requester alone is granted every cycle.
- Requester protocol:
  - A requester keeps req and its data stable until it sees gnt.
  - It may drop req without having been granted; the next winner is then recomputed combinationally.
- out_ready while out_valid=0 is ignored.
- No internal state other than ptr and the output register.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with req=32'hFFFFFFFF, out_ready=1 -> out_valid=0, out_data=0, gnt=0 throughout; first edge after release grants source 0.
- Full contention: req=32'hFFFFFFFF, out_ready=1, mux_data follows 8'hA0+sel -> out_src sequence 0,1,...,31,0; out_data 8'hA0..8'hBF; gnt one-hot every cycle; no bubbles.
- Wrap and skip: ptr=30 after granting 29, req bits {3,30} set -> grants 30 then 3, then 30 again.
- Backpressure: out_ready=0 with out_valid=1, out_data=8'h5C, req=32'h00000010 for 5 cycles -> out_data stays 8'h5C, gnt=0; on out_ready=1, same edge loads source 4's word.
- Idle drain: single word held, req=0, out_ready=1 -> out_valid falls to 0 after one edge; ptr unchanged; a later req[7] grants in 1 cycle.
- Reset mid-operation: rst_n=0 while out_valid=1, out_ready=0 -> next edge out_valid=0, out_src=0; arbitration restarts from source 0.
